dll_tx_replay_arbiter: RTL and testbench
========================================

Name: dll_tx_replay_arbiter

Overview:
Parametrised successor to the fixed-width data-link TX path. It assigns sequence numbers to outgoing TLPs and holds every unacknowledged TLP in a replay buffer. ACK/NAK DLLP information from the RX checker retires or replays buffered TLPs, and a replay timer and replay counter guard against lost acknowledgements. It also arbitrates generator DLLPs, replayed TLPs and new TLPs onto one registered TX port feeding the LCRC/PHY stage.

Parameters:
TLP_W, 1152, TLP payload width in bits
DLLP_W, 48, DLLP width in bits
SEQ_W, 12, sequence number width
DEPTH, 16, replay buffer entries; power of 2, at most 2^(SEQ_W-1)
REPLAY_TIMEOUT, 1024, replay timer expiry in cycles
FRAME_W, SEQ_W+TLP_W, TX frame width; must be at least DLLP_W

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
tlp_i  in  TLP_W  new TLP from transaction layer
tlp_valid_i  in  1  new TLP valid
tlp_ready_o  out  1  new TLP accepted when valid and ready both high
dllp_i  in  DLLP_W  DLLP from DLLP generator
dllp_valid_i  in  1  DLLP valid
dllp_ready_o  out  1  DLLP accepted when valid and ready both high
acknak_valid_i  in  1  received ACK/NAK strobe, one cycle
acknak_is_nak_i  in  1  1 = NAK, 0 = ACK
acknak_seq_i  in  SEQ_W  AckNak_Seq_Num
tx_data_o  out  FRAME_W  frame {seq, tlp}; a DLLP is zero-extended into the LSBs
tx_is_dllp_o  out  1  frame is a DLLP
tx_valid_o  out  1  frame valid
tx_ready_i  in  1  downstream ready
retrain_req_o  out  1  one-cycle pulse on replay-number rollover
outstanding_o  out  $clog2(DEPTH)+1  unacknowledged TLP count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; asserting it mid-operation discards the buffer and all state immediately.
- Reset values: next_seq=0, acked_seq=2^SEQ_W-1, outstanding=0, state=NORMAL, replay_timer=0, replay_num=0. All outputs are 0.
- Sequence arithmetic: modulo 2^SEQ_W. Buffer index = seq mod DEPTH.
- Output register: loads when !tx_valid_o || tx_ready_i. While tx_valid_o && !tx_ready_i, tx_data_o and tx_is_dllp_o hold stable.
- Priority per load slot:
  - 1st: DLLP.
  - 2nd: a replay frame when state=REPLAY.
  - 3rd: a new TLP when state=NORMAL and outstanding<DEPTH.
- Handshake rules:
  - dllp_ready_o = load slot available.
  - tlp_ready_o = load slot available && !dllp_valid_i && state=NORMAL && outstanding<DEPTH.
- New TLP acceptance: stored at buf[next_seq mod DEPTH] and emitted as {next_seq, tlp_i}, one-cycle latency into the output register. Then next_seq++ and outstanding++.
- ACK/NAK validity: an ACK/NAK is valid iff d=(acknak_seq_i-acked_seq) mod 2^SEQ_W is in 0..outstanding. Invalid values are ignored with no state change.
- Valid ACK/NAK with d>0: retire d entries (acked_seq=acknak_seq_i, outstanding-=d), reset replay_timer and replay_num.
- Valid NAK: additionally enter REPLAY (ACK never does). Replay starts at acked_seq+1 after the retire.
- Replay timer: counts while outstanding>0 and state=NORMAL. It resets on any retirement and clears when outstanding=0.
- Replay timer expiry: at replay_timer=REPLAY_TIMEOUT-1, enter REPLAY from acked_seq+1 and clear the timer.
- replay_num: increments on every REPLAY entry. The transition 3->0 pulses retrain_req_o for one cycle and replay still proceeds.
- REPLAY state:
  - replay_ptr walks from acked_seq+1 to next_seq-1, emitting {replay_ptr, buf[replay_ptr mod DEPTH]} with the original sequence numbers.
  - Returns to NORMAL in the cycle after the last entry loads.
  - An ACK arriving mid-replay retires entries. If replay_ptr is then behind acked_seq+1 it jumps forward. If outstanding reaches 0, the state returns to NORMAL.
  - A NAK mid-replay restarts the replay from acked_seq+1 and increments replay_num.
- Simultaneous events:
  - An ACK in the same cycle as a TLP acceptance applies both; outstanding = old - d + 1.
  - Timer expiry in the same cycle as a valid ACK with d>0: the ACK wins and there is no replay.
- Full buffer: outstanding=DEPTH forces tlp_ready_o=0. DLLPs still flow.
- outstanding_o reflects the registered count.

Test Plan:
- Reset, then 3 TLPs with tx_ready_i=1 -> frames carry seq 0,1,2 on consecutive cycles, tx_is_dllp_o=0, outstanding_o=3.
- DLLP and TLP valid in the same cycle -> DLLP emitted first with tx_is_dllp_o=1, TLP next cycle; tlp_ready_o=0 in the DLLP cycle.
- 16 TLPs with no ACK, DEPTH=16 -> tlp_ready_o=0 at outstanding=16. Then ACK seq 5 -> outstanding_o=10 and tlp_ready_o=1.
- Seq 0..7 outstanding, NAK seq 3 -> seq 0..3 retired, seq 4..7 replayed in order with their original payloads, then NORMAL.
- No ACK for REPLAY_TIMEOUT cycles with 2 outstanding -> replay of both. Four timeouts in total -> retrain_req_o pulses once, on the 4th.
- tx_ready_i low for 5 cycles mid-replay -> tx_data_o held stable and no frames lost. Also: ACK seq 100 while seq 0..3 are outstanding -> ignored, with no state change.

Source files
------------

// File: rtl/dll_tx_replay_arbiter.sv
// Data-link TX: sequence numbering, replay buffer with ACK/NAK retirement,
// replay timer/counter, and DLLP > replay > new-TLP arbitration onto one registered port.
module dll_tx_replay_arbiter #(
  parameter int TLP_W          = 1152,
  parameter int DLLP_W         = 48,
  parameter int SEQ_W          = 12,
  parameter int DEPTH          = 16,
  parameter int REPLAY_TIMEOUT = 1024,
  parameter int FRAME_W        = SEQ_W + TLP_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TLP_W-1:0]           tlp_i,
  input  logic                       tlp_valid_i,
  output logic                       tlp_ready_o,
  input  logic [DLLP_W-1:0]          dllp_i,
  input  logic                       dllp_valid_i,
  output logic                       dllp_ready_o,
  input  logic                       acknak_valid_i,
  input  logic                       acknak_is_nak_i,
  input  logic [SEQ_W-1:0]           acknak_seq_i,
  output logic [FRAME_W-1:0]         tx_data_o,
  output logic                       tx_is_dllp_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic                       retrain_req_o,
  output logic [$clog2(DEPTH):0]     outstanding_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;
  localparam int TW = (REPLAY_TIMEOUT > 1) ? $clog2(REPLAY_TIMEOUT) : 1;

  typedef enum logic {NORMAL, REPLAY} state_t;

  state_t           state, state_n;
  logic [SEQ_W-1:0] next_seq, next_seq_n;
  logic [SEQ_W-1:0] acked_seq, acked_n;
  logic [SEQ_W-1:0] replay_ptr, ptr_n, restart_ptr, ptr_ofs;
  logic [OW-1:0]    outstanding, out_n;
  logic [TW-1:0]    replay_timer, timer_n;
  logic [1:0]       replay_num, num_base, num_n;
  logic             retrain_n;

  logic [TLP_W-1:0] rbuf [DEPTH];

  logic             load, tlp_ok, tlp_acc, rep_emit;
  logic [SEQ_W-1:0] ack_d;
  logic             ack_ok, retire, nak, expire, enter;

  // Handshakes and event decode
  assign load          = !tx_valid_o || tx_ready_i;
  assign tlp_ok        = (state == NORMAL) && (outstanding < OW'(DEPTH));
  assign dllp_ready_o  = !rst && load;
  assign tlp_ready_o   = !rst && load && !dllp_valid_i && tlp_ok;
  assign tlp_acc       = tlp_valid_i && tlp_ready_o;
  assign rep_emit      = load && !dllp_valid_i && (state == REPLAY);
  assign outstanding_o = outstanding;

  assign ack_d  = acknak_seq_i - acked_seq;
  assign ack_ok = acknak_valid_i && (ack_d <= SEQ_W'(outstanding));
  assign retire = ack_ok && (ack_d != '0);
  assign nak    = ack_ok && acknak_is_nak_i;
  // A same-cycle retirement supersedes timer expiry.
  assign expire = (state == NORMAL) && (outstanding != '0) &&
                  (replay_timer == TW'(REPLAY_TIMEOUT - 1)) && !retire;

  always_comb begin
    state_n     = state;
    acked_n     = retire ? acknak_seq_i : acked_seq;
    next_seq_n  = next_seq + SEQ_W'(tlp_acc);
    out_n       = outstanding - (retire ? OW'(ack_d) : '0) + OW'(tlp_acc);
    restart_ptr = acked_n + SEQ_W'(1);
    ptr_n       = replay_ptr + SEQ_W'(rep_emit);
    ptr_ofs     = ptr_n - acked_seq - SEQ_W'(1);
    enter       = (nak || expire) && (out_n != '0);

    if (enter) begin
      state_n = REPLAY;
      ptr_n   = restart_ptr;
    end else if (state == REPLAY) begin
      // Entries retired ahead of the replay pointer are skipped, not resent.
      if (retire && (ptr_ofs < ack_d))
        ptr_n = restart_ptr;
      if (ptr_n == next_seq_n)
        state_n = NORMAL;
    end

    num_base  = retire ? 2'd0 : replay_num;
    num_n     = num_base + 2'(enter);
    retrain_n = enter && (num_base == 2'd3);

    if (retire || enter || (out_n == '0))
      timer_n = '0;
    else if (state == NORMAL)
      timer_n = replay_timer + TW'(1);
    else
      timer_n = replay_timer;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= NORMAL;
      next_seq      <= '0;
      acked_seq     <= '1;
      replay_ptr    <= '0;
      outstanding   <= '0;
      replay_timer  <= '0;
      replay_num    <= '0;
      retrain_req_o <= 1'b0;
      tx_data_o     <= '0;
      tx_is_dllp_o  <= 1'b0;
      tx_valid_o    <= 1'b0;
    end else begin
      state         <= state_n;
      next_seq      <= next_seq_n;
      acked_seq     <= acked_n;
      replay_ptr    <= ptr_n;
      outstanding   <= out_n;
      replay_timer  <= timer_n;
      replay_num    <= num_n;
      retrain_req_o <= retrain_n;
      if (load) begin
        if (dllp_valid_i) begin
          tx_data_o    <= FRAME_W'(dllp_i);
          tx_is_dllp_o <= 1'b1;
          tx_valid_o   <= 1'b1;
        end else if (rep_emit) begin
          tx_data_o    <= {replay_ptr, rbuf[replay_ptr[IW-1:0]]};
          tx_is_dllp_o <= 1'b0;
          tx_valid_o   <= 1'b1;
        end else if (tlp_acc) begin
          tx_data_o    <= {next_seq, tlp_i};
          tx_is_dllp_o <= 1'b0;
          tx_valid_o   <= 1'b1;
        end else begin
          tx_valid_o   <= 1'b0;
        end
      end
    end
  end

  // Replay storage carries no reset; occupancy is tracked by the sequence registers.
  always_ff @(posedge clk) begin
    if (tlp_acc)
      rbuf[next_seq[IW-1:0]] <= tlp_i;
  end

endmodule

// File: tb/tb_dll_tx_replay_arbiter.sv
// Directed bench for dll_tx_replay_arbiter with an expected-frame scoreboard queue.
module tb_dll_tx_replay_arbiter;
  localparam int TLP_W  = 64;
  localparam int DLLP_W = 48;
  localparam int SEQ_W  = 12;
  localparam int DEPTH  = 16;
  localparam int RT     = 1024;
  localparam int FW     = SEQ_W + TLP_W;
  localparam int OW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [TLP_W-1:0]  tlp_data = '0;
  logic              tlp_valid = 1'b0;
  logic              tlp_ready;
  logic [DLLP_W-1:0] dllp_data = '0;
  logic              dllp_valid = 1'b0;
  logic              dllp_ready;
  logic              ak_valid = 1'b0;
  logic              ak_nak = 1'b0;
  logic [SEQ_W-1:0]  ak_seq = '0;
  logic [FW-1:0]     tx_data;
  logic              tx_is_dllp;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              retrain;
  logic [OW-1:0]     outstanding;

  always #5 clk = ~clk;

  dll_tx_replay_arbiter #(
    .TLP_W(TLP_W), .DLLP_W(DLLP_W), .SEQ_W(SEQ_W), .DEPTH(DEPTH), .REPLAY_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst),
    .tlp_i(tlp_data), .tlp_valid_i(tlp_valid), .tlp_ready_o(tlp_ready),
    .dllp_i(dllp_data), .dllp_valid_i(dllp_valid), .dllp_ready_o(dllp_ready),
    .acknak_valid_i(ak_valid), .acknak_is_nak_i(ak_nak), .acknak_seq_i(ak_seq),
    .tx_data_o(tx_data), .tx_is_dllp_o(tx_is_dllp), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .retrain_req_o(retrain), .outstanding_o(outstanding)
  );

  int             tests = 0;
  int             fails = 0;
  int             retrain_cnt = 0;
  int             cycles = 0;
  int             nseq = 0;
  bit             tlp_fired, dllp_fired;
  logic [FW:0]    expq [$];
  logic [TLP_W-1:0] pay [DEPTH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW:0] tf(input int seq);
    return {1'b0, SEQ_W'(seq), pay[seq % DEPTH]};
  endfunction

  // One clock: sample handshakes and the outgoing frame just before the edge.
  task automatic cyc();
    logic [FW:0] e;
    #1;
    tlp_fired  = tlp_valid && tlp_ready;
    dllp_fired = dllp_valid && dllp_ready;
    if (tx_valid && tx_ready) begin
      if (expq.size() == 0) chk("unexpected_frame", 128'(expq.size()), 128'(1));
      else begin
        e = expq.pop_front();
        chk("frame", 128'({tx_is_dllp, tx_data}), 128'(e));
      end
    end
    @(posedge clk); #1;
    cycles++;
    if (retrain) retrain_cnt++;
  endtask

  task automatic send_tlp();
    pay[nseq % DEPTH] = {$urandom, $urandom};
    tlp_data  = pay[nseq % DEPTH];
    tlp_valid = 1'b1;
    expq.push_back(tf(nseq));
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (tlp_fired) break;
    end
    if (!tlp_fired) chk("tlp_accept_timeout", 128'(tlp_fired), 128'(1));
    tlp_valid = 1'b0;
    nseq++;
  endtask

  task automatic ack(input logic [SEQ_W-1:0] s, input bit is_nak);
    ak_valid = 1'b1; ak_seq = s; ak_nak = is_nak;
    cyc();
    ak_valid = 1'b0; ak_nak = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (expq.size() != 0 && n < lim) begin cyc(); n++; end
    chk("drain_empty", 128'(expq.size()), 128'(0));
    cyc(); cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tlp_valid = 1'b0; dllp_valid = 1'b0; ak_valid = 1'b0; ak_nak = 1'b0; tx_ready = 1'b1;
    expq.delete();
    nseq = 0; retrain_cnt = 0;
    #2;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [FW:0] held;
    int c0, n;

    // Reset values
    #3;
    chk("rst_tx_valid", 128'(tx_valid), 128'(0));
    chk("rst_tx_data", 128'(tx_data), 128'(0));
    chk("rst_is_dllp", 128'(tx_is_dllp), 128'(0));
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_retrain", 128'(retrain), 128'(0));
    chk("rst_tlp_ready", 128'(tlp_ready), 128'(0));
    chk("rst_dllp_ready", 128'(dllp_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Three back-to-back TLPs
    c0 = cycles;
    repeat (3) send_tlp();
    chk("tlp_b2b_cycles", 128'(cycles - c0), 128'(3));
    drain(20);
    chk("outstanding_3", 128'(outstanding), 128'(3));

    // DLLP wins over a simultaneous TLP
    do_reset();
    dllp_data  = {$urandom, 16'hA5A5};
    dllp_valid = 1'b1;
    pay[0]     = {$urandom, $urandom};
    tlp_data   = pay[0];
    tlp_valid  = 1'b1;
    expq.push_back({1'b1, FW'(dllp_data)});
    expq.push_back(tf(0));
    #1;
    chk("dllp_cycle_tlp_ready", 128'(tlp_ready), 128'(0));
    chk("dllp_cycle_dllp_ready", 128'(dllp_ready), 128'(1));
    cyc();
    chk("dllp_fired", 128'(dllp_fired), 128'(1));
    chk("tlp_held_off", 128'(tlp_fired), 128'(0));
    dllp_valid = 1'b0;
    cyc();
    chk("tlp_after_dllp", 128'(tlp_fired), 128'(1));
    tlp_valid = 1'b0; nseq = 1;
    drain(20);
    chk("outstanding_1", 128'(outstanding), 128'(1));

    // Full buffer, then partial ACK
    do_reset();
    repeat (16) send_tlp();
    drain(40);
    chk("outstanding_full", 128'(outstanding), 128'(16));
    pay[0]    = {$urandom, $urandom};
    tlp_data  = pay[0];
    tlp_valid = 1'b1;
    #1;
    chk("full_tlp_ready", 128'(tlp_ready), 128'(0));
    dllp_data  = {$urandom, 16'h5A5A};
    dllp_valid = 1'b1;
    expq.push_back({1'b1, FW'(dllp_data)});
    cyc();
    chk("full_dllp_flows", 128'(dllp_fired), 128'(1));
    chk("full_tlp_blocked", 128'(tlp_fired), 128'(0));
    dllp_valid = 1'b0;
    expq.push_back(tf(16));
    ack(12'd5, 1'b0);
    chk("ack5_outstanding", 128'(outstanding), 128'(10));
    cyc();
    chk("ack5_tlp_ready", 128'(tlp_fired), 128'(1));
    tlp_valid = 1'b0; nseq = 17;
    drain(20);
    chk("outstanding_11", 128'(outstanding), 128'(11));

    // NAK replays the unacknowledged tail in order
    do_reset();
    repeat (8) send_tlp();
    drain(20);
    for (int s = 4; s < 8; s++) expq.push_back(tf(s));
    ack(12'd3, 1'b1);
    drain(20);
    chk("nak_outstanding", 128'(outstanding), 128'(4));
    chk("nak_back_normal", 128'(tlp_ready), 128'(1));
    chk("nak_no_retrain", 128'(retrain_cnt), 128'(0));

    // Replay timer: four expiries, retrain on the fourth
    do_reset();
    repeat (2) send_tlp();
    drain(20);
    for (int r = 0; r < 4; r++) begin
      expq.push_back(tf(0));
      expq.push_back(tf(1));
      n = 0;
      while (expq.size() != 0 && n < 1300) begin cyc(); n++; end
      chk("timeout_replayed", 128'(expq.size()), 128'(0));
      chk("timeout_window", 128'(n >= 1000 && n <= 1040), 128'(1));
      chk("retrain_count", 128'(retrain_cnt), 128'(r == 3 ? 1 : 0));
    end
    chk("timeout_outstanding", 128'(outstanding), 128'(2));

    // Downstream stall mid-replay
    do_reset();
    repeat (4) send_tlp();
    drain(20);
    for (int s = 0; s < 4; s++) expq.push_back(tf(s));
    ack(12'hFFF, 1'b1);
    cyc(); cyc();
    tx_ready = 1'b0;
    #1;
    held = {tx_is_dllp, tx_data};
    chk("stall_valid", 128'(tx_valid), 128'(1));
    repeat (5) begin
      cyc();
      chk("stall_hold", 128'({tx_is_dllp, tx_data}), 128'(held));
    end
    tx_ready = 1'b1;
    drain(20);
    chk("stall_outstanding", 128'(outstanding), 128'(4));

    // Out-of-window ACK is ignored; later valid ACK uses the untouched state
    ack(12'd100, 1'b0);
    chk("bad_ack_outstanding", 128'(outstanding), 128'(4));
    drain(5);
    ack(12'd1, 1'b0);
    chk("ack1_outstanding", 128'(outstanding), 128'(2));

    // ACK and TLP acceptance in the same cycle
    pay[4 % DEPTH] = {$urandom, $urandom};
    tlp_data  = pay[4 % DEPTH];
    tlp_valid = 1'b1;
    expq.push_back(tf(4));
    ak_valid = 1'b1; ak_seq = 12'd2; ak_nak = 1'b0;
    cyc();
    chk("simul_tlp_fired", 128'(tlp_fired), 128'(1));
    ak_valid = 1'b0; tlp_valid = 1'b0; nseq = 5;
    drain(20);
    chk("simul_outstanding", 128'(outstanding), 128'(2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
